// File: rtl/wb_arbiter.sv
// Writeback arbiter merging the main pipeline and the long-latency unit into one
// register-file write port, plus a busy scoreboard for long-latency destinations.
module wb_arbiter #(
  parameter int unsigned N          = 32,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_valid,
  output logic         a_ready,
  input  logic [4:0]   a_rd,
  input  logic [N-1:0] a_data,
  input  logic         b_valid,
  output logic         b_ready,
  input  logic [4:0]   b_rd,
  input  logic [N-1:0] b_data,
  input  logic         issue_valid,
  input  logic [4:0]   issue_rd,
  output logic [4:0]   write_reg,
  output logic [N-1:0] write_data,
  output logic         regWrite,
  output logic [31:0]  busy,
  output logic         waw_err
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned REG_W = 5;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [REG_W-1:0] write_reg_q, write_reg_d;
  logic [N-1:0]     write_data_q, write_data_d;
  logic             reg_write_q, reg_write_d;
  logic [31:0]      busy_q, busy_d;
  logic             waw_err_q, waw_err_d;

  logic starved;
  logic fire_a;
  logic fire_b;

  // B wins outright once it has been refused STARVE_MAX cycles in a row
  always_comb begin
    starved = (starve_cnt_q == STARVE_LIM);
    a_ready = !(b_valid && starved);
    b_ready = !a_valid || starved;
    fire_a  = a_valid && a_ready;
    fire_b  = b_valid && b_ready;
  end

  always_comb begin
    starve_cnt_d = '0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    reg_write_d  = 1'b0;
    busy_d       = busy_q;
    waw_err_d    = 1'b0;

    if (b_valid && !fire_b) begin
      starve_cnt_d = starved ? starve_cnt_q : starve_cnt_q + CNT_W'(1);
    end

    // Writes to x0 complete the handshake but never reach the register file
    if (fire_a && (a_rd != '0)) begin
      write_reg_d  = a_rd;
      write_data_d = a_data;
      reg_write_d  = 1'b1;
      waw_err_d    = busy_q[a_rd];
    end else if (fire_b && (b_rd != '0)) begin
      write_reg_d  = b_rd;
      write_data_d = b_data;
      reg_write_d  = 1'b1;
    end

    // Issue is applied after retire so a same-index re-issue keeps the bit set
    if (fire_b) begin
      busy_d[b_rd] = 1'b0;
    end
    if (issue_valid) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt_q <= '0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      reg_write_q  <= 1'b0;
      busy_q       <= '0;
      waw_err_q    <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      reg_write_q  <= reg_write_d;
      busy_q       <= busy_d;
      waw_err_q    <= waw_err_d;
    end
  end

  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign regWrite   = reg_write_q;
  assign busy       = busy_q;
  assign waw_err    = waw_err_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, A writes, x0 drop, starvation, scoreboard, WAW.
module tb_wb_arbiter;

  localparam int unsigned N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         a_valid, b_valid, issue_valid;
  logic         a_ready, b_ready;
  logic [4:0]   a_rd, b_rd, issue_rd;
  logic [N-1:0] a_data, b_data;
  logic [4:0]   write_reg;
  logic [N-1:0] write_data;
  logic         regWrite;
  logic [31:0]  busy;
  logic         waw_err;

  int total = 0;
  int bad   = 0;

  wb_arbiter #(.N(N), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .write_reg(write_reg), .write_data(write_data), .regWrite(regWrite),
    .busy(busy), .waw_err(waw_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid = 1'b0; a_rd = '0; a_data = '0;
    b_valid = 1'b0; b_rd = '0; b_data = '0;
    issue_valid = 1'b0; issue_rd = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a_valid = 1'($urandom); a_rd = 5'($urandom); a_data = $urandom;
      b_valid = 1'($urandom); b_rd = 5'($urandom); b_data = $urandom;
      issue_valid = 1'($urandom); issue_rd = 5'($urandom);
      tick();
    end
    total++; if (regWrite !== 1'b0) begin bad++; $display("FAIL reset_regwrite got=%b exp=0", regWrite); end
    total++; if (write_reg !== 5'd0) begin bad++; $display("FAIL reset_write_reg got=%0d exp=0", write_reg); end
    total++; if (write_data !== 32'h0) begin bad++; $display("FAIL reset_write_data got=%h exp=0", write_data); end
    total++; if (busy !== 32'h0) begin bad++; $display("FAIL reset_busy got=%h exp=0", busy); end
    total++; if (waw_err !== 1'b0) begin bad++; $display("FAIL reset_waw got=%b exp=0", waw_err); end
    idle();
    rst = 1'b1;
    #1;
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL reset_a_ready got=%b exp=1", a_ready); end
    total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL reset_b_ready got=%b exp=1", b_ready); end
  endtask

  task automatic test_single_a();
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
    tick();
    idle();
    total++; if (regWrite !== 1'b1) begin bad++; $display("FAIL single_a_we got=%b exp=1", regWrite); end
    total++; if (write_reg !== 5'd5) begin bad++; $display("FAIL single_a_reg got=%0d exp=5", write_reg); end
    total++; if (write_data !== 32'hDEADBEEF) begin bad++; $display("FAIL single_a_data got=%h exp=deadbeef", write_data); end
    tick();
    total++; if (regWrite !== 1'b0) begin bad++; $display("FAIL single_a_we_off got=%b exp=0", regWrite); end
    total++; if (write_reg !== 5'd5) begin bad++; $display("FAIL single_a_reg_hold got=%0d exp=5", write_reg); end
    total++; if (write_data !== 32'hDEADBEEF) begin bad++; $display("FAIL single_a_data_hold got=%h exp=deadbeef", write_data); end
  endtask

  task automatic test_x0();
    a_valid = 1'b1; a_rd = 5'd0; a_data = 32'h1234;
    #1;
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL x0_a_ready got=%b exp=1", a_ready); end
    tick();
    idle();
    total++; if (regWrite !== 1'b0) begin bad++; $display("FAIL x0_we got=%b exp=0", regWrite); end
  endtask

  task automatic test_starvation();
    b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h55;
    for (int c = 0; c < 3; c++) begin
      a_valid = 1'b1; a_rd = 5'(c + 1); a_data = 32'(c + 100);
      #1;
      total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL starve_a_ready_c%0d got=%b exp=1", c, a_ready); end
      total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL starve_b_ready_c%0d got=%b exp=0", c, b_ready); end
      tick();
      total++; if (write_reg !== 5'(c + 1) || regWrite !== 1'b1) begin bad++; $display("FAIL starve_a_write_c%0d got=%0d/%b exp=%0d/1", c, write_reg, regWrite, c + 1); end
    end
    a_rd = 5'd4; a_data = 32'h44;
    #1;
    total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL starve_force_a_ready got=%b exp=0", a_ready); end
    total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL starve_force_b_ready got=%b exp=1", b_ready); end
    tick();
    b_valid = 1'b0;
    #1;
    total++; if (regWrite !== 1'b1 || write_reg !== 5'd7 || write_data !== 32'h55) begin bad++; $display("FAIL starve_b_write got=%b/%0d/%h exp=1/7/55", regWrite, write_reg, write_data); end
    b_valid = 1'b1; b_rd = 5'd8; b_data = 32'h66;
    #1;
    total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL starve_cnt_cleared got=%b exp=0", b_ready); end
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL starve_a_resume got=%b exp=1", a_ready); end
    b_valid = 1'b0;
    tick();
    idle();
    total++; if (write_reg !== 5'd4 || write_data !== 32'h44) begin bad++; $display("FAIL starve_a_held got=%0d/%h exp=4/44", write_reg, write_data); end
    total++; if (busy !== 32'h0) begin bad++; $display("FAIL starve_busy got=%h exp=0", busy); end
  endtask

  task automatic test_scoreboard();
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    idle();
    total++; if (busy !== 32'h0000_0200) begin bad++; $display("FAIL sb_set got=%h exp=00000200", busy); end
    issue_valid = 1'b1; issue_rd = 5'd9;
    b_valid = 1'b1; b_rd = 5'd9; b_data = 32'h99;
    #1;
    total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL sb_b_ready got=%b exp=1", b_ready); end
    tick();
    idle();
    total++; if (busy !== 32'h0000_0200) begin bad++; $display("FAIL sb_set_wins got=%h exp=00000200", busy); end
    total++; if (regWrite !== 1'b1 || write_reg !== 5'd9 || write_data !== 32'h99) begin bad++; $display("FAIL sb_b_write got=%b/%0d/%h exp=1/9/99", regWrite, write_reg, write_data); end
    b_valid = 1'b1; b_rd = 5'd9; b_data = 32'h77;
    tick();
    idle();
    total++; if (busy !== 32'h0) begin bad++; $display("FAIL sb_clear got=%h exp=0", busy); end
    issue_valid = 1'b1; issue_rd = 5'd0;
    tick();
    idle();
    total++; if (busy !== 32'h0) begin bad++; $display("FAIL sb_x0_issue got=%h exp=0", busy); end
  endtask

  task automatic test_waw();
    issue_valid = 1'b1; issue_rd = 5'd12;
    tick();
    idle();
    total++; if (busy !== 32'h0000_1000) begin bad++; $display("FAIL waw_busy got=%h exp=00001000", busy); end
    a_valid = 1'b1; a_rd = 5'd12; a_data = 32'hABCD;
    tick();
    a_rd = 5'd13; a_data = 32'h1313;
    total++; if (waw_err !== 1'b1) begin bad++; $display("FAIL waw_pulse got=%b exp=1", waw_err); end
    total++; if (regWrite !== 1'b1 || write_reg !== 5'd12 || write_data !== 32'hABCD) begin bad++; $display("FAIL waw_write got=%b/%0d/%h exp=1/12/abcd", regWrite, write_reg, write_data); end
    total++; if (busy !== 32'h0000_1000) begin bad++; $display("FAIL waw_busy_kept got=%h exp=00001000", busy); end
    tick();
    idle();
    total++; if (waw_err !== 1'b0) begin bad++; $display("FAIL waw_one_cycle got=%b exp=0", waw_err); end
    total++; if (write_reg !== 5'd13) begin bad++; $display("FAIL waw_next_write got=%0d exp=13", write_reg); end
  endtask

  task automatic test_mid_reset();
    issue_valid = 1'b1; issue_rd = 5'd20;
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h33;
    b_valid = 1'b1; b_rd = 5'd12; b_data = 32'hCC;
    tick();
    issue_valid = 1'b0;
    total++; if (busy !== 32'h0010_1000) begin bad++; $display("FAIL mrst_busy_pre got=%h exp=00101000", busy); end
    rst = 1'b0;
    tick();
    total++; if (busy !== 32'h0) begin bad++; $display("FAIL mrst_busy got=%h exp=0", busy); end
    total++; if (regWrite !== 1'b0) begin bad++; $display("FAIL mrst_we got=%b exp=0", regWrite); end
    total++; if (write_reg !== 5'd0 || waw_err !== 1'b0) begin bad++; $display("FAIL mrst_outs got=%0d/%b exp=0/0", write_reg, waw_err); end
    rst = 1'b1;
    idle();
    tick();
  endtask

  initial begin
    idle();
    rst = 1'b0;
    #1;
    test_reset();
    test_single_a();
    test_x0();
    test_starvation();
    test_scoreboard();
    test_waw();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
